// File: rtl/pcie_chk_pkg.sv
// rtl/pcie_chk_pkg.sv - shared types and constants for the PCIe BAS write-stream checker
package pcie_chk_pkg;

   localparam int FLIT_BYTES = 64;

   typedef enum logic [3:0] {
      ERR_NONE  = 4'd0,
      ERR_SEQ   = 4'd1,
      ERR_ADDR  = 4'd2,
      ERR_PTR   = 4'd3,
      ERR_BURST = 4'd4
   } error_code_t;

   typedef enum logic [1:0] {
      WR_NONE     = 2'd0,
      WR_PERIODIC = 2'd1,
      WR_LFSR     = 2'd2
   } waitreq_mode_t;

   function automatic int flits_per_req(input int req_size, input int write_pointer);
      return (req_size + FLIT_BYTES - 1) / FLIT_BYTES + write_pointer;
   endfunction

endpackage

// File: rtl/pcie_waitreq_gen.sv
// rtl/pcie_waitreq_gen.sv - registered waitrequest backpressure pattern generator
module pcie_waitreq_gen
   import pcie_chk_pkg::*;
#(
   parameter waitreq_mode_t MODE = WR_NONE
) (
   input  logic clk,
   input  logic rst_n,
   output logic waitrequest
);

   logic [1:0]  cnt, cnt_nx;
   logic [15:0] lfsr, lfsr_nx;

   // Waitrequest is computed from the next counter/LFSR state so its registered value tracks the current state.
   always_comb begin
      cnt_nx  = cnt + 2'd1;
      lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         lfsr        <= 16'hACE1;
         waitrequest <= 1'b0;
      end else begin
         cnt  <= cnt_nx;
         lfsr <= lfsr_nx;
         case (MODE)
            WR_PERIODIC: waitrequest <= (cnt_nx == 2'd3);
            WR_LFSR:     waitrequest <= (lfsr_nx[1:0] == 2'd0);
            default:     waitrequest <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/pcie_dma_checker.sv
// rtl/pcie_dma_checker.sv - multi-queue PCIe BAS write-stream sink and checker
module pcie_dma_checker
   import pcie_chk_pkg::*;
#(
   parameter int NB_QUEUES          = 4,
   parameter int BUF_FLITS          = 128,
   parameter int REQ_SIZE           = 64,
   parameter int WRITE_POINTER      = 1,
   parameter int TARGET_NB_REQUESTS = 10000,
   parameter int DRAIN_CYCLES       = 10,
   parameter int WAITREQ_MODE       = 0
) (
   input  logic         pcie_clk,
   input  logic         pcie_reset_n,
   input  logic         pcie_bas_write,
   input  logic [63:0]  pcie_bas_address,
   input  logic [511:0] pcie_bas_writedata,
   input  logic [3:0]   pcie_bas_burstcount,
   output logic         pcie_bas_waitrequest,
   output logic         done,
   output logic         error,
   output logic [3:0]   error_code,
   output logic [4:0]   error_queue,
   output logic [63:0]  rx_flit_cnt,
   output logic [63:0]  req_cnt
);

   localparam int OFF_W     = (BUF_FLITS > 1) ? $clog2(BUF_FLITS) : 1;
   localparam int QSEL_W    = (NB_QUEUES > 1) ? $clog2(NB_QUEUES) : 1;
   localparam int REQ_FLITS = (REQ_SIZE + FLIT_BYTES - 1) / FLIT_BYTES;
   localparam int FPR       = flits_per_req(REQ_SIZE, WRITE_POINTER);
   localparam int FI_W      = $clog2(FPR + 1);

   logic [31:0]       seq      [NB_QUEUES];
   logic [FI_W-1:0]   flit_idx [NB_QUEUES];
   logic [OFF_W-1:0]  exp_off  [NB_QUEUES];

   logic              in_burst;
   logic [QSEL_W-1:0] burst_q;
   logic [63:0]       burst_addr;
   logic [3:0]        remaining;
   logic [31:0]       drain;

   logic              accept, is_ptr, last_flit, bad_burst;
   logic [63:0]       cur_addr;
   logic [QSEL_W-1:0] cur_q;
   logic [OFF_W-1:0]  cur_off;
   error_code_t       err_now;
   logic              unused_bits;

   pcie_waitreq_gen #(
      .MODE(waitreq_mode_t'(WAITREQ_MODE[1:0]))
   ) u_waitreq (
      .clk         (pcie_clk),
      .rst_n       (pcie_reset_n),
      .waitrequest (pcie_bas_waitrequest)
   );

   // Address and burstcount are only meaningful on a first beat; later beats use the latched burst context.
   always_comb begin
      accept    = pcie_bas_write && !pcie_bas_waitrequest;
      cur_addr  = in_burst ? burst_addr : pcie_bas_address;
      cur_q     = in_burst ? burst_q :
                  ((NB_QUEUES > 1) ? pcie_bas_address[6+OFF_W +: QSEL_W] : '0);
      cur_off   = cur_addr[6 +: OFF_W];
      is_ptr    = (WRITE_POINTER != 0) && (flit_idx[cur_q] == FI_W'(REQ_FLITS));
      last_flit = (flit_idx[cur_q] == FI_W'(FPR - 1));
      bad_burst = !in_burst && (pcie_bas_burstcount == 4'd0 || pcie_bas_burstcount > 4'd8);
      err_now   = ERR_NONE;
      if (bad_burst)
         err_now = ERR_BURST;
      else if (!is_ptr) begin
         if (pcie_bas_writedata[511:480] != seq[cur_q])
            err_now = ERR_SEQ;
         else if (cur_off != exp_off[cur_q])
            err_now = ERR_ADDR;
      end else if (!cur_addr[63] || pcie_bas_writedata[31:0] != 32'(exp_off[cur_q]))
         err_now = ERR_PTR;
   end

   assign unused_bits = ^{pcie_bas_writedata[479:32], cur_addr[62:6+OFF_W], cur_addr[5:0]};

   always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
      if (!pcie_reset_n) begin
         for (int i = 0; i < NB_QUEUES; i++) begin
            seq[i]      <= '0;
            flit_idx[i] <= '0;
            exp_off[i]  <= '0;
         end
         in_burst    <= 1'b0;
         burst_q     <= '0;
         burst_addr  <= '0;
         remaining   <= '0;
         drain       <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         error_code  <= '0;
         error_queue <= '0;
         rx_flit_cnt <= '0;
         req_cnt     <= '0;
      end else begin
         if (accept) begin
            rx_flit_cnt <= rx_flit_cnt + 64'd1;
            if (!is_ptr)
               exp_off[cur_q] <= exp_off[cur_q] + OFF_W'(1);
            if (last_flit) begin
               flit_idx[cur_q] <= '0;
               seq[cur_q]      <= seq[cur_q] + 32'd1;
               req_cnt         <= req_cnt + 64'd1;
            end else
               flit_idx[cur_q] <= flit_idx[cur_q] + FI_W'(1);

            if (in_burst) begin
               burst_addr <= burst_addr + 64'd64;
               remaining  <= remaining - 4'd1;
               if (remaining == 4'd1)
                  in_burst <= 1'b0;
            end else if (!bad_burst && pcie_bas_burstcount > 4'd1) begin
               in_burst   <= 1'b1;
               burst_q    <= cur_q;
               burst_addr <= pcie_bas_address + 64'd64;
               remaining  <= pcie_bas_burstcount - 4'd1;
            end

            if (err_now != ERR_NONE && !error) begin
               error       <= 1'b1;
               error_code  <= err_now;
               error_queue <= 5'(cur_q);
            end
         end

         if (accept && last_flit && req_cnt == 64'(TARGET_NB_REQUESTS - 1)) begin
            drain <= 32'(DRAIN_CYCLES);
            if (DRAIN_CYCLES == 0)
               done <= 1'b1;
         end else if (drain != '0) begin
            drain <= drain - 32'd1;
            if (drain == 32'd1)
               done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_dma_checker.sv
// tb/tb_pcie_dma_checker.sv - directed self-checking bench for pcie_dma_checker
module tb_pcie_dma_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic         a_write, b_write;
   logic [63:0]  a_addr, b_addr;
   logic [511:0] a_data, b_data;
   logic [3:0]   a_bc, b_bc;
   logic         a_wr, a_done, a_err, b_wr, b_done, b_err;
   logic [3:0]   a_code, b_code;
   logic [4:0]   a_eq, b_eq;
   logic [63:0]  a_rx, a_req, b_rx, b_req;

   int n_cmp = 0;
   int n_bad = 0;
   int saw_hi = 0;
   int saw_lo = 0;
   int a_seq[4];
   int a_off[4];

   pcie_dma_checker #(
      .NB_QUEUES(4), .BUF_FLITS(128), .REQ_SIZE(64), .WRITE_POINTER(1),
      .TARGET_NB_REQUESTS(804), .DRAIN_CYCLES(10), .WAITREQ_MODE(0)
   ) dut_a (
      .pcie_clk(clk), .pcie_reset_n(rst_n), .pcie_bas_write(a_write),
      .pcie_bas_address(a_addr), .pcie_bas_writedata(a_data), .pcie_bas_burstcount(a_bc),
      .pcie_bas_waitrequest(a_wr), .done(a_done), .error(a_err), .error_code(a_code),
      .error_queue(a_eq), .rx_flit_cnt(a_rx), .req_cnt(a_req)
   );

   pcie_dma_checker #(
      .NB_QUEUES(4), .BUF_FLITS(128), .REQ_SIZE(256), .WRITE_POINTER(1),
      .TARGET_NB_REQUESTS(3), .DRAIN_CYCLES(10), .WAITREQ_MODE(2)
   ) dut_b (
      .pcie_clk(clk), .pcie_reset_n(rst_n), .pcie_bas_write(b_write),
      .pcie_bas_address(b_addr), .pcie_bas_writedata(b_data), .pcie_bas_burstcount(b_bc),
      .pcie_bas_waitrequest(b_wr), .done(b_done), .error(b_err), .error_code(b_code),
      .error_queue(b_eq), .rx_flit_cnt(b_rx), .req_cnt(b_req)
   );

   always @(negedge clk) begin
      if (b_write) begin
         if (b_wr) saw_hi++;
         else      saw_lo++;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk_addr(input int q, input int off, input bit ptr);
      logic [63:0] a;
      a     = (64'(q) << 13) | (64'(off % 128) << 6);
      a[63] = ptr;
      return a;
   endfunction

   task automatic beat_a(input logic [63:0] addr, input logic [3:0] bc,
                         input logic [31:0] hi, input logic [31:0] lo);
      a_write = 1'b1; a_addr = addr; a_bc = bc;
      a_data = '0; a_data[511:480] = hi; a_data[31:0] = lo;
      @(posedge clk); #1;
      a_write = 1'b0; a_addr = '0;
   endtask

   task automatic req_a(input int q);
      beat_a(mk_addr(q, a_off[q], 1'b0), 4'd1, 32'(a_seq[q]), 32'd0);
      a_off[q] = (a_off[q] + 1) % 128;
      beat_a(mk_addr(q, 0, 1'b1), 4'd1, 32'd0, 32'(a_off[q]));
      a_seq[q]++;
   endtask

   task automatic beat_b(input logic [63:0] addr, input logic [3:0] bc,
                         input logic [31:0] hi, input logic [31:0] lo);
      bit acc;
      int n;
      b_write = 1'b1; b_addr = addr; b_bc = bc;
      b_data = '0; b_data[511:480] = hi; b_data[31:0] = lo;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 64) begin
         acc = !b_wr;
         @(posedge clk); #1;
         n++;
      end
      check_eq("b_beat_accepted", 64'(acc), 64'd1);
      b_write = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int q = 0; q < 4; q++) begin
         a_seq[q] = 0;
         a_off[q] = 0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      a_write = 0; a_addr = '0; a_data = '0; a_bc = '0;
      b_write = 0; b_addr = '0; b_data = '0; b_bc = '0;
      rst_n = 1'b0;
      #3;
      check_eq("rst_a_waitreq", 64'(a_wr), 64'd0);
      check_eq("rst_b_waitreq", 64'(b_wr), 64'd0);
      check_eq("rst_a_done", 64'(a_done), 64'd0);
      check_eq("rst_a_error", 64'(a_err), 64'd0);
      check_eq("rst_a_code", 64'(a_code), 64'd0);
      check_eq("rst_a_queue", 64'(a_eq), 64'd0);
      check_eq("rst_a_rx", a_rx, 64'd0);
      check_eq("rst_a_req", a_req, 64'd0);
      do_reset();

      // Instance B: 256-byte requests, bursts, LFSR backpressure with write held high.
      beat_b(mk_addr(2, 0, 1'b0), 4'd4, 32'd0, 32'd0);
      for (int k = 0; k < 3; k++) beat_b(64'hDEAD_BEEF_0000_0000, 4'd0, 32'd0, 32'd0);
      beat_b(mk_addr(2, 0, 1'b1), 4'd1, 32'd0, 32'd4);
      check_eq("b_burst_req", b_req, 64'd1);
      check_eq("b_burst_rx", b_rx, 64'd5);
      check_eq("b_burst_err", 64'(b_err), 64'd0);
      for (int k = 0; k < 4; k++) beat_b(mk_addr(0, k, 1'b0), 4'd1, 32'd0, 32'd0);
      beat_b(mk_addr(0, 0, 1'b1), 4'd1, 32'd0, 32'd4);
      beat_b(mk_addr(2, 4, 1'b0), 4'd4, 32'd1, 32'd0);
      for (int k = 0; k < 3; k++) beat_b(64'h1234_5678_0000_0000, 4'd0, 32'd1, 32'd0);
      beat_b(mk_addr(2, 0, 1'b1), 4'd1, 32'd0, 32'd8);
      check_eq("b_total_rx", b_rx, 64'd15);
      check_eq("b_total_req", b_req, 64'd3);
      check_eq("b_total_err", 64'(b_err), 64'd0);
      repeat (9) @(posedge clk);
      #1;
      check_eq("b_done_early", 64'(b_done), 64'd0);
      @(posedge clk); #1;
      check_eq("b_done", 64'(b_done), 64'd1);
      check_eq("b_saw_stall", 64'(saw_hi != 0), 64'd1);
      check_eq("b_saw_ready", 64'(saw_lo != 0), 64'd1);

      // Instance A: single beats, interleaved queues with offset wrap, termination.
      check_eq("a_idle_waitreq", 64'(a_wr), 64'd0);
      check_eq("a_idle_rx", a_rx, 64'd0);
      req_a(0);
      req_a(0);
      check_eq("a_q0_rx", a_rx, 64'd4);
      check_eq("a_q0_req", a_req, 64'd2);
      for (int r = 0; r < 200; r++)
         for (int q = 0; q < 4; q++) req_a(q);
      check_eq("a_wrap_rx", a_rx, 64'd1604);
      check_eq("a_wrap_req", a_req, 64'd802);
      check_eq("a_wrap_err", 64'(a_err), 64'd0);
      check_eq("a_wrap_done", 64'(a_done), 64'd0);
      req_a(1);
      req_a(1);
      check_eq("a_target_req", a_req, 64'd804);
      repeat (9) @(posedge clk);
      #1;
      check_eq("a_done_early", 64'(a_done), 64'd0);
      @(posedge clk); #1;
      check_eq("a_done", 64'(a_done), 64'd1);
      req_a(2);
      check_eq("a_post_rx", a_rx, 64'd1610);
      check_eq("a_post_req", a_req, 64'd805);
      check_eq("a_post_err", 64'(a_err), 64'd0);
      check_eq("a_post_done", 64'(a_done), 64'd1);

      // Sequence error on queue 1, then an address error that must not overwrite it.
      do_reset();
      check_eq("a_rst2_done", 64'(a_done), 64'd0);
      for (int k = 0; k < 3; k++) req_a(1);
      beat_a(mk_addr(1, 3, 1'b0), 4'd1, 32'd5, 32'd0);
      check_eq("a_seq_err", 64'(a_err), 64'd1);
      check_eq("a_seq_code", 64'(a_code), 64'd1);
      check_eq("a_seq_queue", 64'(a_eq), 64'd1);
      beat_a(mk_addr(2, 9, 1'b0), 4'd1, 32'd0, 32'd0);
      check_eq("a_sticky_code", 64'(a_code), 64'd1);
      check_eq("a_sticky_queue", 64'(a_eq), 64'd1);
      check_eq("a_sticky_rx", a_rx, 64'd8);

      // Illegal burstcounts.
      do_reset();
      beat_a(mk_addr(3, 0, 1'b0), 4'd0, 32'd0, 32'd0);
      check_eq("a_bc0_code", 64'(a_code), 64'd4);
      check_eq("a_bc0_queue", 64'(a_eq), 64'd3);
      do_reset();
      beat_a(mk_addr(1, 0, 1'b0), 4'd9, 32'd0, 32'd0);
      check_eq("a_bc9_code", 64'(a_code), 64'd4);
      check_eq("a_bc9_queue", 64'(a_eq), 64'd1);

      // Reset pulsed in the middle of a 2-beat burst.
      do_reset();
      beat_a(mk_addr(3, 0, 1'b1), 4'd2, 32'd0, 32'd0);
      check_eq("a_midburst_rx", a_rx, 64'd1);
      rst_n = 1'b0;
      #2;
      check_eq("a_async_rx", a_rx, 64'd0);
      check_eq("a_async_err", 64'(a_err), 64'd0);
      check_eq("a_async_req", a_req, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      beat_a(mk_addr(0, 0, 1'b0), 4'd1, 32'd0, 32'd0);
      beat_a(mk_addr(0, 0, 1'b1), 4'd1, 32'd0, 32'd1);
      check_eq("a_fresh_err", 64'(a_err), 64'd0);
      check_eq("a_fresh_rx", a_rx, 64'd2);
      check_eq("a_fresh_req", a_req, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
